// File: rtl/cpu_multicycle.sv
// Multicycle RV32I subset core: FETCH -> DECODE -> EXECUTE -> {MEM ->} WRITEBACK, terminal HALT.
// Optional retire counter (retired_o) is built when CPU_MC_RETIRE_CNT_EN is defined.
module cpu_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] pc_o,
  output logic        halt_o,
  output logic [1:0]  cause_o,
`ifdef CPU_MC_RETIRE_CNT_EN
  output logic [31:0] retired_o,
`endif
  output logic [2:0]  state_o
);
  // Memory handshake: the core holds req/we/addr/wdata steady while req=1 and
  // ready=0; the transfer completes on the posedge where req=1 and ready=1.
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
    S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_R = 7'h33, OP_IMM = 7'h13, OP_LUI = 7'h37, OP_AUIPC = 7'h17,
                         OP_JAL = 7'h6f, OP_JALR = 7'h67, OP_BR = 7'h63, OP_LOAD = 7'h03,
                         OP_STORE = 7'h23;
  localparam logic [31:0] WAIT_LIM = (MAX_WAIT == 0) ? 32'd0 : 32'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q, res_q, npc_q, maddr_q, wdata_q, wait_q;
  logic [1:0]  cause_q, fault;
  logic [31:0] rf [32];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  logic is_r, is_jal, is_jalr, is_br, is_lw, is_sw, is_lui, is_auipc, trap, legal;
  assign is_r     = opcode == OP_R;
  assign is_lui   = opcode == OP_LUI;
  assign is_auipc = opcode == OP_AUIPC;
  assign is_jal   = opcode == OP_JAL;
  assign is_jalr  = opcode == OP_JALR;
  assign is_br    = opcode == OP_BR;
  assign is_lw    = opcode == OP_LOAD;
  assign is_sw    = opcode == OP_STORE;
  assign trap     = (ir_q == 32'h0000_0073) || (ir_q == 32'h0010_0073);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R:     legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
      OP_IMM:   legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                        (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
      OP_JALR:  legal = f3 == 3'b000;
      OP_BR:    legal = f3 != 3'b010 && f3 != 3'b011;
      OP_LOAD, OP_STORE: legal = f3 == 3'b010;
      default:  legal = 1'b0;
    endcase
  end

  logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j, op_b, alu, pc_plus4;
  logic [31:0] next_pc, ls_addr, result;
  logic        taken, redirect, misalign;
  assign rs1_v    = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_v    = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u    = {ir_q[31:12], 12'd0};
  assign imm_j    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign op_b     = is_r ? rs2_v : imm_i;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    alu = 32'd0;
    case (f3)
      3'b000:  alu = (is_r && f7[5]) ? rs1_v - op_b : rs1_v + op_b;
      3'b001:  alu = rs1_v << op_b[4:0];
      3'b010:  alu = {31'd0, $signed(rs1_v) < $signed(op_b)};
      3'b011:  alu = {31'd0, rs1_v < op_b};
      3'b100:  alu = rs1_v ^ op_b;
      3'b101:  alu = f7[5] ? 32'($signed(rs1_v) >>> op_b[4:0]) : rs1_v >> op_b[4:0];
      3'b110:  alu = rs1_v | op_b;
      default: alu = rs1_v & op_b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:  taken = rs1_v == rs2_v;
      3'b001:  taken = rs1_v != rs2_v;
      3'b100:  taken = $signed(rs1_v) < $signed(rs2_v);
      3'b101:  taken = $signed(rs1_v) >= $signed(rs2_v);
      3'b110:  taken = rs1_v < rs2_v;
      3'b111:  taken = rs1_v >= rs2_v;
      default: taken = 1'b0;
    endcase
  end

  // All address sums are plain 32-bit adds, so they wrap modulo 2^32.
  assign next_pc  = is_jal ? pc_q + imm_j :
                    is_jalr ? ((rs1_v + imm_i) & ~32'd1) :
                    (is_br && taken) ? pc_q + imm_b : pc_plus4;
  assign redirect = is_jal || is_jalr || (is_br && taken);
  assign ls_addr  = rs1_v + (is_sw ? imm_s : imm_i);
  assign misalign = (redirect && next_pc[1:0] != 2'd0) ||
                    ((is_lw || is_sw) && ls_addr[1:0] != 2'd0);
  assign result   = is_lui ? imm_u : is_auipc ? pc_q + imm_u :
                    (is_jal || is_jalr) ? pc_plus4 : alu;

  logic req_state, timeout;
  assign req_state = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout   = (MAX_WAIT != 0) && req_state && !mem_ready_i && (wait_q == WAIT_LIM);

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fault   = 2'd0;
    case (state_q)
      S_FETCH:   if (mem_ready_i) state_d = S_DECODE;
                 else if (timeout) begin state_d = S_HALT; fault = 2'd3; end
      S_DECODE:  if (trap) begin state_d = S_HALT; fault = 2'd1; end
                 else if (!legal) begin state_d = S_HALT; fault = 2'd2; end
                 else state_d = S_EXECUTE;
      S_EXECUTE: if (misalign) begin state_d = S_HALT; fault = 2'd2; end
                 else if (is_lw || is_sw) state_d = S_MEM;
                 else state_d = S_WB;
      S_MEM:     if (mem_ready_i) state_d = S_WB;
                 else if (timeout) begin state_d = S_HALT; fault = 2'd3; end
      S_WB:      state_d = S_FETCH;
      default:   state_d = S_HALT;
    endcase
  end

  always_comb begin
    mem_req_o   = req_state && !reset;
    mem_we_o    = (state_q == S_MEM) && is_sw;
    mem_addr_o  = (state_q == S_MEM) ? maddr_q : pc_q;
    mem_wdata_o = wdata_q;
    halt_o      = state_q == S_HALT;
    state_o     = state_q;
  end

  assign pc_o    = pc_q;
  assign cause_o = cause_q;

`ifdef CPU_MC_RETIRE_CNT_EN
  logic [31:0] retired_q;
  assign retired_o = retired_q;
  always_ff @(posedge clock) begin
    if (reset)                  retired_q <= 32'd0;
    else if (state_q == S_WB)   retired_q <= retired_q + 32'd1;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      cause_q <= 2'd0;
      wait_q  <= 32'd0;
    end else begin
      wait_q <= (req_state && !mem_ready_i) ? wait_q + 32'd1 : 32'd0;
      if (state_d == S_HALT && state_q != S_HALT) cause_q <= fault;
      if (state_q == S_WB) pc_q <= npc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == S_FETCH && mem_ready_i) ir_q <= mem_rdata_i;
    if (state_q == S_EXECUTE) begin
      res_q   <= result;
      npc_q   <= next_pc;
      maddr_q <= ls_addr;
      wdata_q <= rs2_v;
    end
    if (state_q == S_MEM && mem_ready_i && !is_sw) res_q <= mem_rdata_i;
  end

  // Register file keeps its contents across reset; x0 writes are dropped.
  always_ff @(posedge clock) begin
    if (!reset && state_q == S_WB && !is_br && !is_sw && rd != 5'd0) rf[rd] <= res_q;
  end
endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: word memory with programmable latency and a scoreboard of
// expected memory transfers; retire counter checks run when CPU_MC_RETIRE_CNT_EN is defined.
module tb_cpu_multicycle;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_o, mem_we_o, mem_ready_i = 1'b0, halt_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = 32'd0, pc_o;
  logic [1:0]  cause_o;
  logic [2:0]  state_o;
`ifdef CPU_MC_RETIRE_CNT_EN
  logic [31:0] retired_o;
`endif

  cpu_multicycle #(.RESET_PC(RESET_PC), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .pc_o(pc_o), .halt_o(halt_o), .cause_o(cause_o),
`ifdef CPU_MC_RETIRE_CNT_EN
    .retired_o(retired_o),
`endif
    .state_o(state_o)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem [0:63];
  logic [64:0] exp_q[$];
  int          lat = 0;
  int          cnt = 0;
  bit          stall_forever = 1'b0;
  bit          resp_off = 1'b0;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_sig = '0;

  // Memory responder: ready rises on the negedge after `lat` stall cycles.
  always @(negedge clock) begin
    if (reset) cnt = 0;
    if (!resp_off) begin
      if (mem_ready_i) begin
        mem_ready_i = 1'b0;
        cnt = 0;
      end else if (mem_req_o && !stall_forever) begin
        if (cnt >= lat) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = mem[mem_addr_o[7:2]];
        end else cnt++;
      end
    end
  end

  // Scoreboard and stall-stability monitor.
  always @(posedge clock) begin
    logic [64:0] got, exp;
    got = {mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : 32'd0};
    if (prev_stall && mem_req_o) begin
      checks++;
      if (got !== prev_sig) begin
        errors++;
        $display("FAIL stall_stable: got %h, required %h", got, prev_sig);
      end
    end
    if (mem_req_o && mem_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got we/addr/wdata %h, required no transfer", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL sb_transfer: got we/addr/wdata %h, required %h", got, exp);
        end
      end
      if (mem_we_o) mem[mem_addr_o[7:2]] = mem_wdata_o;
    end
    prev_stall = mem_req_o && !mem_ready_i;
    prev_sig   = got;
  end

  function automatic logic [31:0] enc_i(int op, int f3, int rd, int rs1, int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(int rs2, int rs1, int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(int rd, int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  localparam logic [31:0] ECALL = 32'h0000_0073;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
  endtask

  // Leaves the core in reset with an empty scoreboard; caller pushes, then releases.
  task automatic begin_run();
    reset = 1'b1;
    tick(2);
    exp_q.delete();
  endtask

  task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({we, a, we ? d : 32'd0});
  endtask

  task automatic wait_halt(input int budget, output bit ok);
    int n = 0;
    while (!halt_o && n < budget) begin tick(1); n++; end
    ok = halt_o;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    checks++;
    if (mem_req_o !== 1'b0 || halt_o !== 1'b0 || cause_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b halt=%b cause=%0d, required 0 0 0", mem_req_o, halt_o, cause_o);
    end
    checks++;
    if (pc_o !== RESET_PC || state_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: pc=%h state=%0d, required pc=%h state=0", pc_o, state_o, RESET_PC);
    end
  endtask

  task automatic test_alu_timing();
    bit ok;
    clear_mem();
    mem[0] = enc_i(7'h13, 0, 1, 0, 5);
    mem[1] = enc_s(1, 0, 32'h40);
    mem[2] = ECALL;
    begin_run();
    push(0, 32'h0, 0); push(0, 32'h4, 0); push(1, 32'h40, 5); push(0, 32'h8, 0);
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== RESET_PC) begin
      errors++;
      $display("FAIL first_fetch: req=%b addr=%h, required 1 %h", mem_req_o, mem_addr_o, RESET_PC);
    end
    tick(3);
    checks++;
    if (pc_o !== 32'h0) begin errors++; $display("FAIL alu_pc_early: pc=%h, required 00000000", pc_o); end
    tick(1);
    checks++;
    if (pc_o !== 32'h4) begin errors++; $display("FAIL alu_4cyc: pc=%h, required 00000004", pc_o); end
    tick(4);
    checks++;
    if (pc_o !== 32'h4) begin errors++; $display("FAIL sw_pc_early: pc=%h, required 00000004", pc_o); end
    tick(1);
    checks++;
    if (pc_o !== 32'h8) begin errors++; $display("FAIL sw_5cyc: pc=%h, required 00000008", pc_o); end
    wait_halt(50, ok);
    checks++;
    if (!ok || cause_o !== 2'd1 || pc_o !== 32'h8) begin
      errors++;
      $display("FAIL alu_halt: halt=%b cause=%0d pc=%h, required 1 1 00000008", halt_o, cause_o, pc_o);
    end
`ifdef CPU_MC_RETIRE_CNT_EN
    checks++;
    if (retired_o !== 32'd2) begin errors++; $display("FAIL alu_retired: got %0d, required 2", retired_o); end
`endif
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL alu_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_store_load_stall();
    bit ok;
    clear_mem();
    lat = 3;
    mem[0]  = enc_j(0, 32'h40);
    mem[16] = enc_i(7'h13, 0, 1, 0, 5);
    mem[17] = enc_s(1, 0, 8);
    mem[18] = enc_i(7'h03, 2, 2, 0, 8);
    mem[19] = enc_s(2, 0, 12);
    mem[20] = ECALL;
    begin_run();
    push(0, 32'h0, 0); push(0, 32'h40, 0); push(0, 32'h44, 0); push(1, 32'h8, 5);
    push(0, 32'h48, 0); push(0, 32'h8, 0); push(0, 32'h4c, 0); push(1, 32'hc, 5);
    push(0, 32'h50, 0);
    reset = 1'b0;
    wait_halt(300, ok);
    checks++;
    if (!ok || cause_o !== 2'd1 || pc_o !== 32'h50) begin
      errors++;
      $display("FAIL sl_halt: halt=%b cause=%0d pc=%h, required 1 1 00000050", halt_o, cause_o, pc_o);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sl_pending: got %0d, required 0", exp_q.size()); end
    lat = 0;
  endtask

  task automatic test_branch();
    bit ok;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] tgt;
      tgt = (k == 0) ? 32'h08 : 32'h14;
      clear_mem();
      mem[0] = enc_j(0, 32'h10);
      mem[4] = enc_b(k, 0, 0, -8);
      mem[tgt[7:2]] = ECALL;
      begin_run();
      push(0, 32'h0, 0); push(0, 32'h10, 0); push(0, tgt, 0);
      reset = 1'b0;
      wait_halt(60, ok);
      checks++;
      if (!ok || cause_o !== 2'd1 || pc_o !== tgt) begin
        errors++;
        $display("FAIL branch_%0d: halt=%b cause=%0d pc=%h, required 1 1 %h", k, halt_o, cause_o, pc_o, tgt);
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL branch_pending: got %0d, required 0", exp_q.size()); end
    end
  endtask

  task automatic test_jump();
    bit ok;
    // Link values and JALR bit-0 clearing.
    clear_mem();
    mem[0] = enc_j(5, 32'h20);
    mem[8] = enc_s(5, 0, 32'h40);
    mem[9] = enc_i(7'h67, 0, 6, 5, 13);
    mem[4] = enc_s(6, 0, 32'h44);
    mem[5] = ECALL;
    begin_run();
    push(0, 32'h0, 0); push(0, 32'h20, 0); push(1, 32'h40, 32'h4); push(0, 32'h24, 0);
    push(0, 32'h10, 0); push(1, 32'h44, 32'h28); push(0, 32'h14, 0);
    reset = 1'b0;
    wait_halt(80, ok);
    checks++;
    if (!ok || cause_o !== 2'd1 || pc_o !== 32'h14) begin
      errors++;
      $display("FAIL jump_link: halt=%b cause=%0d pc=%h, required 1 1 00000014", halt_o, cause_o, pc_o);
    end
    // Address wrap: jump to FFFFFFFC, then +8 wraps to 4.
    clear_mem();
    mem[0]  = enc_i(7'h67, 0, 0, 0, -4);
    mem[63] = enc_j(0, 8);
    mem[1]  = ECALL;
    begin_run();
    push(0, 32'h0, 0); push(0, 32'hffff_fffc, 0); push(0, 32'h4, 0);
    reset = 1'b0;
    wait_halt(60, ok);
    checks++;
    if (!ok || cause_o !== 2'd1 || pc_o !== 32'h4) begin
      errors++;
      $display("FAIL jump_wrap: halt=%b cause=%0d pc=%h, required 1 1 00000004", halt_o, cause_o, pc_o);
    end
    // Misaligned jump target.
    clear_mem();
    mem[0] = enc_j(0, 6);
    begin_run();
    push(0, 32'h0, 0);
    reset = 1'b0;
    wait_halt(40, ok);
    checks++;
    if (!ok || cause_o !== 2'd2 || pc_o !== 32'h0) begin
      errors++;
      $display("FAIL jump_misalign: halt=%b cause=%0d pc=%h, required 1 2 00000000", halt_o, cause_o, pc_o);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL jump_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_illegal();
    bit ok;
    logic [31:0] bad [3];
    logic [1:0]  bad_cause [3];
    clear_mem();
    mem[0] = enc_i(7'h13, 0, 3, 0, 7);
    mem[1] = enc_i(7'h03, 2, 3, 0, 2);
    begin_run();
    push(0, 32'h0, 0); push(0, 32'h4, 0);
    reset = 1'b0;
    wait_halt(40, ok);
    tick(4);
    checks++;
    if (!ok || halt_o !== 1'b1 || cause_o !== 2'd2 || pc_o !== 32'h4 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL lw_misalign: halt=%b cause=%0d pc=%h req=%b, required 1 2 00000004 0", halt_o, cause_o, pc_o, mem_req_o);
    end
    // x3 must still hold 7 after the faulting load and a reset.
    clear_mem();
    mem[0] = enc_s(3, 0, 32'h40);
    mem[1] = ECALL;
    begin_run();
    push(0, 32'h0, 0); push(1, 32'h40, 7); push(0, 32'h4, 0);
    reset = 1'b0;
    wait_halt(40, ok);
    checks++;
    if (!ok || cause_o !== 2'd1) begin
      errors++;
      $display("FAIL x3_keep_halt: halt=%b cause=%0d, required 1 1", halt_o, cause_o);
    end
    bad[0] = 32'h0220_8033; bad_cause[0] = 2'd2;
    bad[1] = 32'h0010_0073; bad_cause[1] = 2'd1;
    bad[2] = 32'h0000_000f; bad_cause[2] = 2'd2;
    for (int k = 0; k < 3; k++) begin
      clear_mem();
      mem[0] = bad[k];
      begin_run();
      push(0, 32'h0, 0);
      reset = 1'b0;
      wait_halt(30, ok);
      checks++;
      if (!ok || cause_o !== bad_cause[k] || pc_o !== 32'h0) begin
        errors++;
        $display("FAIL decode_%0d: halt=%b cause=%0d pc=%h, required 1 %0d 00000000", k, halt_o, cause_o, pc_o, bad_cause[k]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL illegal_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_mem();
    mem[0] = ECALL;
    stall_forever = 1'b1;
    begin_run();
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== RESET_PC) begin
      errors++;
      $display("FAIL to_req: req=%b addr=%h, required 1 %h", mem_req_o, mem_addr_o, RESET_PC);
    end
    tick(3);
    checks++;
    if (halt_o !== 1'b0) begin errors++; $display("FAIL to_early: halt=%b, required 0", halt_o); end
    tick(1);
    checks++;
    if (halt_o !== 1'b1 || cause_o !== 2'd3 || pc_o !== 32'h0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL to_halt: halt=%b cause=%0d pc=%h req=%b, required 1 3 00000000 0", halt_o, cause_o, pc_o, mem_req_o);
    end
    stall_forever = 1'b0;
    begin_run();
    checks++;
    if (halt_o !== 1'b0 || cause_o !== 2'd0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL to_reset: halt=%b cause=%0d req=%b, required 0 0 0", halt_o, cause_o, mem_req_o);
    end
    push(0, 32'h0, 0);
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== RESET_PC) begin
      errors++;
      $display("FAIL to_restart: req=%b addr=%h, required 1 %h", mem_req_o, mem_addr_o, RESET_PC);
    end
    wait_halt(30, ok);
    checks++;
    if (!ok || cause_o !== 2'd1) begin errors++; $display("FAIL to_rerun: halt=%b cause=%0d, required 1 1", halt_o, cause_o); end
  endtask

  task automatic test_reset_mid_request();
    bit ok;
    clear_mem();
    mem[0] = enc_i(7'h13, 0, 4, 0, 9);
    mem[1] = enc_s(4, 0, 32'h48);
    mem[2] = ECALL;
    resp_off = 1'b1;
    begin_run();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hffff_ffff;
    #1;
    checks++;
    if (mem_req_o !== 1'b0) begin errors++; $display("FAIL mid_req_gate: req=%b, required 0", mem_req_o); end
    tick(1);
    mem_ready_i = 1'b0;
    resp_off = 1'b0;
    checks++;
    if (state_o !== 3'd0 || halt_o !== 1'b0 || pc_o !== RESET_PC) begin
      errors++;
      $display("FAIL mid_abandon: state=%0d halt=%b pc=%h, required 0 0 %h", state_o, halt_o, pc_o, RESET_PC);
    end
    tick(1);
    exp_q.delete();
    push(0, 32'h0, 0); push(0, 32'h4, 0); push(1, 32'h48, 9); push(0, 32'h8, 0);
    reset = 1'b0;
    wait_halt(60, ok);
    checks++;
    if (!ok || cause_o !== 2'd1 || pc_o !== 32'h8) begin
      errors++;
      $display("FAIL mid_rerun: halt=%b cause=%0d pc=%h, required 1 1 00000008", halt_o, cause_o, pc_o);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mid_pending: got %0d, required 0", exp_q.size()); end
  endtask

`ifdef CPU_MC_RETIRE_CNT_EN
  task automatic test_retire();
    bit ok;
    clear_mem();
    for (int i = 0; i < 3; i++) mem[i] = enc_i(7'h13, 0, 10 + i, 0, i + 1);
    mem[3] = ECALL;
    begin_run();
    checks++;
    if (retired_o !== 32'd0) begin errors++; $display("FAIL retire_reset: got %0d, required 0", retired_o); end
    for (int i = 0; i < 4; i++) push(0, 32'(4 * i), 0);
    reset = 1'b0;
    wait_halt(60, ok);
    checks++;
    if (!ok || cause_o !== 2'd1 || retired_o !== 32'd3) begin
      errors++;
      $display("FAIL retire_count: halt=%b cause=%0d retired=%0d, required 1 1 3", halt_o, cause_o, retired_o);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_timing();
    test_store_load_stall();
    test_branch();
    test_jump();
    test_illegal();
    test_timeout();
    test_reset_mid_request();
`ifdef CPU_MC_RETIRE_CNT_EN
    test_retire();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_multicycle.md
CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter MAX_WAIT, default 255, is the number of cycles a request may stall before the core halts with a timeout; 0 disables the timeout.
REQ-003 The port clock SHALL be an input of width 1 and is the single clock; all state changes on posedge.
REQ-004 The port reset SHALL be an input of width 1, synchronous and active-high.
REQ-005 The port mem_req_o SHALL be an output of width 1 and signals that a memory request is valid.
REQ-006 The port mem_we_o SHALL be an output of width 1 and is 1 for a store, 0 for a fetch or load.
REQ-007 The port mem_addr_o SHALL be an output of width 32 and carries the word-aligned byte address.
REQ-008 The port mem_wdata_o SHALL be an output of width 32 and carries the store data.
REQ-009 The port mem_ready_i SHALL be an input of width 1 and signals completion of the request.
REQ-010 The port mem_rdata_i SHALL be an input of width 32 and carries read data, valid when mem_ready_i=1.
REQ-011 The port pc_o SHALL be an output of width 32 and carries the current PC.
REQ-012 The port halt_o SHALL be an output of width 1 and is sticky high once the core stops.
REQ-013 The port cause_o SHALL be an output of width 2 and encodes 0 none, 1 ECALL/EBREAK, 2 illegal/misaligned, 3 timeout.

Function
REQ-014 The core SHALL use the state machine FETCH -> DECODE -> EXECUTE -> {MEM ->} WRITEBACK -> FETCH, plus a terminal HALT state.
REQ-015 The core SHALL execute RV32I R-type, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH (all six), LW and SW; every other opcode or funct SHALL go to HALT with cause 2.
REQ-016 mem_req_o SHALL be high only in FETCH and MEM, and addr, we and wdata SHALL stay stable while req=1 and ready=0.
REQ-017 A request SHALL complete on the posedge where req=1 and ready=1; in FETCH, mem_rdata_i SHALL be latched into the instruction register and the state SHALL advance to DECODE.
REQ-018 ALU, LUI, AUIPC and jump instructions with zero-wait memory SHALL take exactly 4 cycles; LW and SW SHALL take 5.
REQ-019 The PC SHALL update only in WRITEBACK: to PC+4; to PC+imm for a taken branch or JAL; to (rs1+imm)&~1 for JALR.
REQ-020 All address arithmetic SHALL be modulo 2^32, so PC 32'hFFFF_FFFC + 4 wraps to 0.
REQ-021 A load/store address with addr[1:0]!=0, or a jump/branch target with target[1:0]!=0, SHALL go to HALT with cause 2, with no memory request and no register write.
REQ-022 Writes to x0 SHALL be discarded; JAL and JALR SHALL write PC+4 to rd.
REQ-023 ECALL and EBREAK SHALL go to HALT with cause 1.
REQ-024 In HALT, mem_req_o SHALL be 0 and pc_o SHALL hold the PC of the faulting instruction; the core SHALL leave HALT only on reset.
REQ-025 When MAX_WAIT>0 and ready stays low for MAX_WAIT consecutive request cycles, the core SHALL go to HALT with cause 3.

Reset
REQ-026 While reset=1 at a posedge, the core SHALL set state to FETCH, pc to RESET_PC, halt_o to 0, cause_o to 0 and clear the wait counter.
REQ-027 mem_req_o SHALL be forced to 0 during any cycle in which reset=1.
REQ-028 A reset asserted mid-request SHALL abandon the request, and a late mem_ready_i SHALL be ignored.
REQ-029 The register file contents SHALL NOT be cleared by reset.

Configuration
REQ-030 When CPU_MC_RETIRE_CNT_EN is defined, the core SHALL add the output retired_o[31:0], which resets to 0, increments by 1 in each WRITEBACK cycle, wraps at 2^32, and does not count instructions that halt.
REQ-031 When CPU_MC_RETIRE_CNT_EN is undefined, the retired_o port and its counter SHALL be absent.

Verification
REQ-032 Reset then ADDI x1,x0,5 with zero-wait memory -> first mem_addr_o=RESET_PC; x1=5 after 4 cycles; pc_o=4.
REQ-033 SW x1,8(x0) then LW x2,8(x0), with ready delayed 3 cycles each -> a store with addr=8 and wdata=5 whose signals stay stable during the stall; x2=5.
REQ-034 BEQ x0,x0,-8 at PC 0x10 -> next fetch address 0x08; BNE x0,x0 -> next fetch address 0x14.
REQ-035 LW x3,2(x0) -> halt_o=1, cause_o=2, no MEM request, x3 unchanged.
REQ-036 Fetch with ready held low and MAX_WAIT=4 -> HALT with cause 3 after 4 cycles; then reset -> fetch restarts at RESET_PC.
REQ-037 ECALL after 3 ALU instructions, with CPU_MC_RETIRE_CNT_EN defined -> halt_o=1, cause_o=1, retired_o=3.
